// File: rtl/merge_stream.sv
// merge_stream: packet-aware 4:1 AXI-Stream merge with a single-entry registered output stage.
// Optional macro MERGE_STREAM_SRC_TAG_EN adds o_tuser carrying the source index of each beat.
module merge_stream #(
    parameter int unsigned WIDTH       = 16,
    parameter logic [3:0]  ACTIVE_MASK = 4'b1111,
    parameter int unsigned PRIO        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i0_tdata,
    input  logic [WIDTH-1:0] i1_tdata,
    input  logic [WIDTH-1:0] i2_tdata,
    input  logic [WIDTH-1:0] i3_tdata,
    input  logic             i0_tlast,
    input  logic             i1_tlast,
    input  logic             i2_tlast,
    input  logic             i3_tlast,
    input  logic             i0_tvalid,
    input  logic             i1_tvalid,
    input  logic             i2_tvalid,
    input  logic             i3_tvalid,
    output logic             i0_tready,
    output logic             i1_tready,
    output logic             i2_tready,
    output logic             i3_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
`ifdef MERGE_STREAM_SRC_TAG_EN
    output logic [1:0]       o_tuser,
`endif
    input  logic             o_tready
);

    localparam int unsigned N_IN = 4;
    localparam int unsigned GW   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t            state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     last_grant;

    logic [WIDTH-1:0]  in_data [N_IN];
    logic [N_IN-1:0]   in_last;
    logic [N_IN-1:0]   in_valid;
    logic [N_IN-1:0]   cand;
    logic [N_IN-1:0]   ready_vec;

    logic              soft_rst;
    logic              rdy;
    logic              accept;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;
    logic              sel_valid;
    logic              arb_hit;
    logic [GW-1:0]     arb_idx;
    logic [GW-1:0]     probe;

    // Gather the four streams into indexable vectors.
    assign in_data[0] = i0_tdata;
    assign in_data[1] = i1_tdata;
    assign in_data[2] = i2_tdata;
    assign in_data[3] = i3_tdata;
    assign in_last    = {i3_tlast,  i2_tlast,  i1_tlast,  i0_tlast};
    assign in_valid   = {i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid};

    assign soft_rst  = ~reset | clear;
    assign rdy       = ~o_tvalid | o_tready;
    assign cand      = in_valid & ACTIVE_MASK;

    assign sel_data  = in_data[grant];
    assign sel_last  = in_last[grant];
    assign sel_valid = in_valid[grant];

    // Arbiter: scan from last_grant+1 for round-robin, from index 0 for fixed priority.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        probe   = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            probe = (PRIO != 0) ? GW'(k) : last_grant + GW'(k + 1);
            if (!arb_hit && cand[probe]) begin
                arb_hit = 1'b1;
                arb_idx = probe;
            end
        end
    end

    // Only the granted input sees ready, and only while the output register can take a beat.
    always_comb begin
        ready_vec = '0;
        if (state == PKT && !soft_rst) begin
            ready_vec[grant] = rdy & ACTIVE_MASK[grant];
        end
    end

    assign accept    = ready_vec[grant] & sel_valid;
    assign i0_tready = ready_vec[0];
    assign i1_tready = ready_vec[1];
    assign i2_tready = ready_vec[2];
    assign i3_tready = ready_vec[3];

    // Grant FSM and output register.
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(3);
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
`ifdef MERGE_STREAM_SRC_TAG_EN
            o_tuser    <= '0;
`endif
        end else begin
            if (accept) begin
                o_tvalid <= 1'b1;
                o_tdata  <= sel_data;
                o_tlast  <= sel_last;
`ifdef MERGE_STREAM_SRC_TAG_EN
                o_tuser  <= grant;
`endif
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        grant <= arb_idx;
                        state <= PKT;
                    end
                end
                PKT: begin
                    // Grant is held through stalls until the tlast beat is taken.
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
